// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth digit source: triplet encodings,
// the serializer state type and sizing helpers used to derive port widths.
package booth_pkg;

  // Two-state serializer: waiting for an operand, or presenting digits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Booth triplet encodings {b(2i+1), b(2i), b(2i-1)} and the multiple they select.
  localparam logic [2:0] B_ZERO   = 3'b000;
  localparam logic [2:0] B_ZERO_N = 3'b111;
  localparam logic [2:0] B_P1_A   = 3'b001;
  localparam logic [2:0] B_P1_B   = 3'b010;
  localparam logic [2:0] B_P2     = 3'b011;
  localparam logic [2:0] B_M2     = 3'b100;
  localparam logic [2:0] B_M1_A   = 3'b101;
  localparam logic [2:0] B_M1_B   = 3'b110;

  // Number of radix-4 digits needed. An unsigned operand needs one extra
  // digit so the top bits are treated as positive (implicit zero sign).
  function automatic int ndig(input int width, input bit signedMode);
    return signedMode ? (width + 1) / 2 : width / 2 + 1;
  endfunction

  // Width of the digit index; a single-digit operand still needs one bit.
  function automatic int idxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Signed multiple (-2..+2) selected by a triplet; handy for downstream users.
  function automatic logic signed [2:0] boothMultiple(input logic [2:0] t);
    logic signed [2:0] m;
    unique case (t)
      B_ZERO, B_ZERO_N: m = 3'sd0;
      B_P1_A, B_P1_B:   m = 3'sd1;
      B_P2:             m = 3'sd2;
      B_M2:             m = -3'sd2;
      default:          m = -3'sd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/booth_digit_serializer.sv
// Radix-4 Booth digit source. Loads a multiplier operand and emits overlapping
// 3-bit triplets LSB digit first, with valid/ready handshakes on both sides,
// a digit index, a last flag and a synchronous flush.
module booth_digit_serializer
  import booth_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1,
  localparam int NDIG  = ndig(WIDTH, SIGNED),
  localparam int SRW   = 2 * NDIG + 1,
  localparam int IW    = idxWidth(NDIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [2:0]       dig,
  output logic [IW-1:0]    dig_idx,
  output logic             dig_last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  state_e               state_q, state_d;
  logic [SRW-1:0]       sr_q, sr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [2*NDIG-1:0]    extData;
  logic                 fillBit;
  logic                 shiftFill;
  logic                 digHs;
  logic                 loadHs;

  // Operand extension to a whole number of digits: copy the real bits, fill
  // the rest with the sign (two's complement) or zero (unsigned).
  assign fillBit = SIGNED ? in_data[WIDTH-1] : 1'b0;

  for (genvar b = 0; b < 2 * NDIG; b++) begin : g_ext
    if (b < WIDTH) begin : g_bit
      assign extData[b] = in_data[b];
    end else begin : g_fill
      assign extData[b] = fillBit;
    end
  end

  // Bits shifted in from the top keep the extended operand's sign intact.
  assign shiftFill = SIGNED ? sr_q[SRW-1] : 1'b0;

  // Outputs are decoded from registered state only; in IDLE everything reads zero.
  assign dig_valid = (state_q == ST_SHIFT);
  assign dig       = dig_valid ? sr_q[2:0] : 3'b000;
  assign dig_idx   = idx_q;
  assign dig_last  = dig_valid && (idx_q == LAST_IDX);

  assign digHs = dig_valid && dig_ready;

  // An operand is accepted when idle, or on the cycle the final digit leaves,
  // which gives zero-bubble back-to-back operation. Flush and reset block it.
  assign in_ready = !rst && !flush && ((state_q == ST_IDLE) || (digHs && dig_last));
  assign loadHs   = in_valid && in_ready;

  // Next-state logic: flush beats load, load beats retire, retire beats shift.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      idx_d   = '0;
    end else if (loadHs) begin
      state_d = ST_SHIFT;
      sr_d    = {extData, 1'b0};
      idx_d   = '0;
    end else if (digHs && dig_last) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      idx_d   = '0;
    end else if (digHs) begin
      sr_d  = {shiftFill, shiftFill, sr_q[SRW-1:2]};
      idx_d = idx_q + IW'(1);
    end
  end

  // State, shift register and digit counter; reset drops any operand at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_booth_digit_serializer.sv
// Self-checking bench for booth_digit_serializer: directed tests on a signed
// 8-bit instance with a digit scoreboard, an unsigned 8-bit directed case, and
// a randomized sweep over several widths checking sum(booth(d_i)*4^i).
module tb_booth_digit_serializer;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Main signed 8-bit DUT
  logic       flush, inValid, inReady, digValid, digReady, digLast;
  logic [7:0] inData;
  logic [2:0] dig;
  logic [1:0] digIdx;

  booth_digit_serializer #(.WIDTH(8), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .dig_valid(digValid), .dig_ready(digReady), .dig(dig),
    .dig_idx(digIdx), .dig_last(digLast)
  );

  // Unsigned 8-bit DUT for the extra-digit case
  logic       uValid, uReady, uDigValid, uDigLast;
  logic [7:0] uData;
  logic [2:0] uDig;
  logic [2:0] uIdx;

  booth_digit_serializer #(.WIDTH(8), .SIGNED(1'b0)) dutU (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(uValid), .in_ready(uReady), .in_data(uData),
    .dig_valid(uDigValid), .dig_ready(1'b1), .dig(uDig),
    .dig_idx(uIdx), .dig_last(uDigLast)
  );

  typedef struct {
    logic [2:0] d;
    logic [1:0] i;
    logic       l;
  } exp_t;

  exp_t   expQ[$];
  longint recon;
  logic   lastInReady;
  logic   lastDigValid;
  logic   sweepGo = 1'b0;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    testsRun++;
    assert (obs === expv)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Independent value of a triplet: -2*b(2i+1) + b(2i) + b(2i-1).
  function automatic longint boothWeight(input logic [2:0] t);
    return -2 * longint'(t[2]) + longint'(t[1]) + longint'(t[0]);
  endfunction

  // Expected digit stream of a signed 8-bit operand.
  task automatic pushOperand(input logic [7:0] v);
    logic [63:0] x;
    exp_t        e;
    x = {{56{v[7]}}, v} << 1;
    for (int i = 0; i < 4; i++) begin
      e.d = x[2*i +: 3];
      e.i = 2'(i);
      e.l = (i == 3);
      expQ.push_back(e);
    end
  endtask

  // Drives one cycle of inputs, checks the visible digit against the
  // scoreboard head, pops it on handshake and records loads.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
    inValid  = v;
    inData   = d;
    digReady = r;
    flush    = f;
    #1;
    lastInReady  = inReady;
    lastDigValid = digValid;
    if (digValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDigit", 64'(digValid), 64'(0));
      end else begin
        checkOutput("dig", 64'(dig), 64'(expQ[0].d));
        checkOutput("digIdx", 64'(digIdx), 64'(expQ[0].i));
        checkOutput("digLast", 64'(digLast), 64'(expQ[0].l));
        if (r && !f) begin
          recon = recon + boothWeight(dig) * (longint'(1) << (2 * int'(digIdx)));
          void'(expQ.pop_front());
        end
      end
    end
    if (v && inReady) pushOperand(d);
    @(posedge clk);
    #1;
  endtask

  logic [2:0] ffDigits [5];
  logic [7:0] bpOps [2];
  longint     bpVals [2];

  initial begin
    ffDigits = '{3'b110, 3'b111, 3'b111, 3'b111, 3'b001};
    bpOps    = '{8'h5B, 8'h93};
    bpVals   = '{91, -109};
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; digReady = 1'b0;
    uValid = 1'b0; uData = '0; recon = 0;

    // Reset values while rst is held
    #2;
    checkOutput("rstInReady", 64'(inReady), 64'(0));
    checkOutput("rstDigValid", 64'(digValid), 64'(0));
    checkOutput("rstDig", 64'(dig), 64'(0));
    checkOutput("rstIdx", 64'(digIdx), 64'(0));
    checkOutput("rstLast", 64'(digLast), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("postRstInReady", 64'(inReady), 64'(1));

    // Signed 8'hB6 with consumer always ready
    applyStimulus(1'b1, 8'hB6, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("b6Valid", 64'(lastDigValid), 64'(1));
    end
    #1 checkOutput("b6FifthValid", 64'(digValid), 64'(0));
    checkOutput("b6Drain", 64'(expQ.size()), 64'(0));

    // Backpressure: ready pattern 1,0,0,1 with value reconstruction
    for (int op = 0; op < 2; op++) begin
      recon = 0;
      applyStimulus(1'b1, bpOps[op], 1'b1, 1'b0);
      for (int k = 0; k < 40 && expQ.size() > 0; k++)
        applyStimulus(1'b0, 8'h00, ((k % 4) == 0) || ((k % 4) == 3), 1'b0);
      checkOutput("bpDrain", 64'(expQ.size()), 64'(0));
      checkOutput("bpValue", 64'(recon), 64'(bpVals[op]));
    end

    // Back-to-back: 8'h01 then 8'h80 with in_valid held
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
    checkOutput("b2bIdleReady", 64'(lastInReady), 64'(1));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'h80, 1'b1, 1'b0);
      checkOutput("b2bReadyA", 64'(lastInReady), 64'(k == 3));
      checkOutput("b2bValidA", 64'(lastDigValid), 64'(1));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("b2bReadyB", 64'(lastInReady), 64'(k == 3));
      checkOutput("b2bValidB", 64'(lastDigValid), 64'(1));
    end
    checkOutput("b2bDrain", 64'(expQ.size()), 64'(0));

    // Flush at idx 2 with a competing load
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("preFlushIdx", 64'(digIdx), 64'(2));
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    checkOutput("flushInReady", 64'(lastInReady), 64'(0));
    expQ.delete();
    flush = 1'b0; inValid = 1'b0;
    #1;
    checkOutput("postFlushValid", 64'(digValid), 64'(0));
    checkOutput("postFlushReady", 64'(inReady), 64'(1));
    checkOutput("postFlushIdx", 64'(digIdx), 64'(0));
    applyStimulus(1'b1, 8'h7F, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("7fDrain", 64'(expQ.size()), 64'(0));

    // Asynchronous reset pulse between edges mid-operand
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncValid", 64'(digValid), 64'(0));
    checkOutput("asyncDig", 64'(dig), 64'(0));
    checkOutput("asyncIdx", 64'(digIdx), 64'(0));
    checkOutput("asyncLast", 64'(digLast), 64'(0));
    checkOutput("asyncReady", 64'(inReady), 64'(0));
    #1 rst = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    checkOutput("postAsyncValid", 64'(digValid), 64'(0));
    checkOutput("postAsyncReady", 64'(inReady), 64'(1));

    // Unsigned 8'hFF: five digits with an extra positive top digit
    uValid = 1'b1; uData = 8'hFF;
    @(posedge clk);
    #1 uValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("ffValid", 64'(uDigValid), 64'(1));
      checkOutput("ffDig", 64'(uDig), 64'(ffDigits[k]));
      checkOutput("ffIdx", 64'(uIdx), 64'(k));
      checkOutput("ffLast", 64'(uDigLast), 64'(k == 4));
      @(posedge clk);
      #1;
    end
    checkOutput("ffSixthValid", 64'(uDigValid), 64'(0));

    // Randomized sweep across widths and signedness
    sweepGo = 1'b1;
    for (int t = 0; t < 20000 && !(sweep[0].doneFlag && sweep[1].doneFlag &&
         sweep[2].doneFlag && sweep[3].doneFlag && sweep[4].doneFlag &&
         sweep[5].doneFlag && sweep[6].doneFlag && sweep[7].doneFlag); t++)
      @(posedge clk);
    checkOutput("sweepDone", 64'({sweep[7].doneFlag, sweep[6].doneFlag, sweep[5].doneFlag,
                sweep[4].doneFlag, sweep[3].doneFlag, sweep[2].doneFlag,
                sweep[1].doneFlag, sweep[0].doneFlag}), 64'hFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // One instance per (WIDTH, SIGNED) pair, each reconstructing random operands.
  for (genvar g = 0; g < 8; g++) begin : sweep
    localparam int W   = (g < 2) ? 2 : (g < 4) ? 7 : (g < 6) ? 8 : 16;
    localparam bit S   = ((g % 2) == 0);
    localparam int N   = S ? (W + 1) / 2 : W / 2 + 1;
    localparam int IWL = (N <= 1) ? 1 : $clog2(N);

    logic           sValid, sInReady, sDigValid, sReady, sLast;
    logic [W-1:0]   sData;
    logic [2:0]     sDig;
    logic [IWL-1:0] sIdx;
    logic           doneFlag = 1'b0;

    booth_digit_serializer #(.WIDTH(W), .SIGNED(S)) sdut (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(sValid), .in_ready(sInReady), .in_data(sData),
      .dig_valid(sDigValid), .dig_ready(sReady), .dig(sDig),
      .dig_idx(sIdx), .dig_last(sLast)
    );

    initial begin
      longint expVal;
      longint sum;
      int     cnt;
      sValid = 1'b0; sData = '0; sReady = 1'b0;
      wait (sweepGo);
      @(posedge clk);
      #1;
      for (int op = 0; op < 12; op++) begin
        sData  = W'($urandom);
        expVal = S ? longint'(signed'(sData)) : longint'(sData);
        sValid = 1'b1;
        #1 checkOutput("sweepInReady", 64'(sInReady), 64'(1));
        @(posedge clk);
        #1 sValid = 1'b0;
        sum = 0;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < N; c++) begin
          sReady = 1'($urandom_range(0, 1));
          if (sDigValid && sReady) begin
            checkOutput("sweepIdx", 64'(sIdx), 64'(cnt));
            checkOutput("sweepLast", 64'(sLast), 64'(cnt == N - 1));
            sum = sum + boothWeight(sDig) * (longint'(1) << (2 * cnt));
            cnt++;
          end
          @(posedge clk);
          #1;
        end
        sReady = 1'b0;
        checkOutput("sweepCount", 64'(cnt), 64'(N));
        checkOutput("sweepValue", 64'(sum), 64'(expVal));
        checkOutput("sweepIdleAfter", 64'(sDigValid), 64'(0));
      end
      doneFlag = 1'b1;
    end
  end

endmodule
